// File: rtl/mmio_reg_bank_if.sv
// Peripheral-bus port bundle for mmio_reg_bank: shared address, write and read strobes,
// and the registered read response.
interface mmio_reg_bank_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    // Strobes are single-cycle and always accepted (no ready). Every cycle with r_en=1
    // produces exactly one r_valid=1 cycle one clock later; r_err qualifies it.
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_en;
    logic                  r_en;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_err;

    modport master (
        output addr, w_data, w_en, r_en,
        input  r_data, r_valid, r_err
    );

    modport slave (
        input  addr, w_data, w_en, r_en,
        output r_data, r_valid, r_err
    );
endinterface

// File: rtl/mmio_reg_bank.sv
// Memory-mapped register bank: RW data registers, W1C status, saturating trigger counter
// and a one-cycle trigger strobe, all with registered outputs.
module mmio_reg_bank #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_REGS   = 4,
    parameter int TRIG_ADDR  = (1 << ADDR_WIDTH) - 1
) (
    input  logic                           clock,
    input  logic                           reset,
    mmio_reg_bank_if.slave                 bus,
    output logic                           trig_pulse,
    output logic [DATA_WIDTH-1:0]          trig_data,
    output logic                           pending,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat
);
    localparam logic [ADDR_WIDTH-1:0] STATUS_A = ADDR_WIDTH'(NUM_REGS);
    localparam logic [ADDR_WIDTH-1:0] TRIG_A   = ADDR_WIDTH'(TRIG_ADDR);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] trig_count;
    logic                  overflow;
    logic [DATA_WIDTH-1:0] rd_value;
    logic                  rd_err;
    logic                  trig_wr;
    logic                  status_wr;

    assign trig_wr   = bus.w_en && (bus.addr == TRIG_A);
    assign status_wr = bus.w_en && (bus.addr == STATUS_A);

    // Read mux sees pre-write state, which gives read-before-write on a shared address.
    always_comb begin
        rd_value = '0;
        rd_err   = 1'b0;
        if (bus.addr < STATUS_A) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (bus.addr == ADDR_WIDTH'(i)) rd_value = regs[i];
            end
        end else if (bus.addr == STATUS_A) begin
            rd_value = DATA_WIDTH'({overflow, pending});
        end else if (bus.addr == TRIG_A) begin
            rd_value = trig_count;
        end else begin
            rd_err = 1'b1;
        end
    end

    always_comb begin
        regs_flat = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_flat[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            trig_data   <= '0;
            trig_count  <= '0;
            trig_pulse  <= 1'b0;
            pending     <= 1'b0;
            overflow    <= 1'b0;
            bus.r_data  <= '0;
            bus.r_valid <= 1'b0;
            bus.r_err   <= 1'b0;
        end else begin
            bus.r_valid <= bus.r_en;
            bus.r_err   <= bus.r_en && rd_err;
            if (bus.r_en) bus.r_data <= rd_value;

            for (int i = 0; i < NUM_REGS; i++) begin
                if (bus.w_en && (bus.addr == ADDR_WIDTH'(i))) regs[i] <= bus.w_data;
            end

            trig_pulse <= trig_wr;
            if (trig_wr) begin
                trig_data <= bus.w_data;
                if (trig_count != '1) trig_count <= trig_count + 1'b1;
                if (pending) overflow <= 1'b1;
                pending <= 1'b1;
            end else if (status_wr) begin
                if (bus.w_data[0]) pending  <= 1'b0;
                if (bus.w_data[1]) overflow <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mmio_reg_bank.sv
// Directed bench for mmio_reg_bank: an address-map model predicts every output each
// cycle, and literal expectations pin the model on the key scenarios.
module tb_mmio_reg_bank;
    localparam int DW = 8;
    localparam int AW = 8;
    localparam int NR = 4;

    logic clock;
    logic reset;
    logic trig_pulse;
    logic [DW-1:0] trig_data;
    logic pending;
    logic [NR*DW-1:0] regs_flat;

    mmio_reg_bank_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    mmio_reg_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .TRIG_ADDR(255)) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus.slave),
        .trig_pulse (trig_pulse),
        .trig_data  (trig_data),
        .pending    (pending),
        .regs_flat  (regs_flat)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // Model state
    logic [DW-1:0] m_regs [NR];
    int            m_count;
    logic          m_pend, m_ovf;
    logic [DW-1:0] m_tdata;
    logic [DW-1:0] e_rdata;
    logic          e_rvalid, e_rerr, e_pulse;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_read(input int a, output logic [DW-1:0] d, output logic e);
        d = '0;
        e = 1'b0;
        if (a < NR) d = m_regs[a];
        else if (a == NR) d = {6'b0, m_ovf, m_pend};
        else if (a == 255) d = m_count[DW-1:0];
        else e = 1'b1;
    endfunction

    task automatic compare_all();
        logic [NR*DW-1:0] e_flat;
        for (int i = 0; i < NR; i++) e_flat[i*DW +: DW] = m_regs[i];
        check("r_valid", {31'b0, bus.r_valid}, {31'b0, e_rvalid});
        check("r_err", {31'b0, bus.r_err}, {31'b0, e_rerr});
        check("r_data_hold", {24'b0, bus.r_data}, {24'b0, e_rdata});
        if (bus.r_valid) begin
            if (exp_q.size() == 0) check("read_queue_empty", 32'd1, 32'd0);
            else check("read_data", {24'b0, bus.r_data}, {24'b0, exp_q.pop_front()});
        end
        check("trig_pulse", {31'b0, trig_pulse}, {31'b0, e_pulse});
        check("trig_data", {24'b0, trig_data}, {24'b0, m_tdata});
        check("pending", {31'b0, pending}, {31'b0, m_pend});
        check("regs_flat", regs_flat, e_flat);
    endtask

    // One clock of stimulus: predict, clock, compare.
    task automatic step(input logic rst, input logic we, input logic re,
                        input int a, input logic [DW-1:0] wd);
        logic [DW-1:0] rd;
        logic er;
        reset      = rst;
        bus.w_en   = we;
        bus.r_en   = re;
        bus.addr   = AW'(a);
        bus.w_data = wd;
        if (rst) begin
            for (int i = 0; i < NR; i++) m_regs[i] = '0;
            m_count = 0; m_pend = 0; m_ovf = 0; m_tdata = '0;
            e_rdata = '0; e_rvalid = 0; e_rerr = 0; e_pulse = 0;
            exp_q.delete();
        end else begin
            e_pulse  = we && (a == 255);
            e_rvalid = re;
            e_rerr   = 1'b0;
            if (re) begin
                model_read(a, rd, er);
                e_rdata = rd;
                e_rerr  = er;
                exp_q.push_back(rd);
            end
            if (we) begin
                if (a < NR) m_regs[a] = wd;
                else if (a == NR) begin
                    if (wd[0]) m_pend = 1'b0;
                    if (wd[1]) m_ovf = 1'b0;
                end else if (a == 255) begin
                    m_tdata = wd;
                    if (m_pend) m_ovf = 1'b1;
                    m_pend = 1'b1;
                    m_count = (m_count < 255) ? m_count + 1 : 255;
                end
            end
        end
        @(posedge clock);
        #1;
        compare_all();
    endtask

    initial begin
        reset = 1'b1; bus.w_en = 0; bus.r_en = 0; bus.addr = '0; bus.w_data = '0;
        step(1, 0, 0, 0, 8'h00);
        step(1, 0, 0, 0, 8'h00);
        check("lit_reset_regs", regs_flat, 32'h0);
        check("lit_reset_pulse", {31'b0, trig_pulse}, 32'd0);

        // Data register write and readback
        step(0, 1, 0, 2, 8'hA5);
        check("lit_reg2", {24'b0, regs_flat[23:16]}, 32'hA5);
        step(0, 0, 1, 2, 8'h00);
        check("lit_read2", {23'b0, bus.r_valid, bus.r_data}, 32'h1A5);
        check("lit_read2_err", {31'b0, bus.r_err}, 32'd0);
        check("lit_flat", regs_flat, 32'h00A5_0000);
        step(0, 1, 0, 0, 8'h5A);
        step(0, 1, 0, 3, 8'hC3);
        step(0, 1, 0, 7, 8'hEE);   // unmapped write, ignored
        step(0, 0, 1, 3, 8'h00);

        // Single trigger
        step(0, 1, 0, 255, 8'h3C);
        check("lit_trig_pulse", {31'b0, trig_pulse}, 32'd1);
        check("lit_trig_data", {24'b0, trig_data}, 32'h3C);
        check("lit_pending", {31'b0, pending}, 32'd1);
        step(0, 0, 0, 0, 8'h00);
        check("lit_pulse_once", {31'b0, trig_pulse}, 32'd0);
        step(0, 0, 1, 4, 8'h00);
        check("lit_status_01", {24'b0, bus.r_data}, 32'h01);

        // Overflow and write-1-to-clear
        step(0, 1, 0, 255, 8'h44);
        step(0, 0, 1, 4, 8'h00);
        check("lit_status_03", {24'b0, bus.r_data}, 32'h03);
        step(0, 1, 0, 4, 8'h01);
        step(0, 0, 1, 4, 8'h00);
        check("lit_status_02", {24'b0, bus.r_data}, 32'h02);
        step(0, 1, 0, 4, 8'hFE);
        step(0, 0, 1, 4, 8'h00);
        check("lit_status_00", {24'b0, bus.r_data}, 32'h00);

        // Back-to-back triggers up to saturation
        for (int i = 0; i < 260; i++) step(0, 1, 0, 255, 8'(i));
        step(0, 0, 1, 255, 8'h00);
        check("lit_count_sat", {24'b0, bus.r_data}, 32'hFF);
        step(0, 0, 1, 100, 8'h00);
        check("lit_unmapped", {22'b0, bus.r_valid, bus.r_err, bus.r_data}, 32'h300);
        step(0, 0, 0, 0, 8'h00);
        step(0, 0, 1, 4, 8'h00);

        // Read-before-write on the same address
        step(0, 1, 0, 1, 8'h11);
        step(0, 1, 1, 1, 8'h77);
        check("lit_rbw_old", {24'b0, bus.r_data}, 32'h11);
        step(0, 0, 1, 1, 8'h00);
        check("lit_rbw_new", {24'b0, bus.r_data}, 32'h77);
        step(0, 1, 1, 4, 8'h03);
        check("lit_rbw_status", {24'b0, bus.r_data}, 32'h03);

        // Reset the cycle after a trigger, with a trigger write dropped
        step(0, 1, 0, 255, 8'h99);
        step(1, 1, 1, 255, 8'h12);
        check("lit_rst_pulse", {31'b0, trig_pulse}, 32'd0);
        check("lit_rst_pending", {31'b0, pending}, 32'd0);
        check("lit_rst_rvalid", {31'b0, bus.r_valid}, 32'd0);
        step(0, 0, 1, 255, 8'h00);
        check("lit_rst_count", {24'b0, bus.r_data}, 32'h00);
        step(0, 0, 0, 0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
